jelly_data_combine_pack_n: RTL and testbench
============================================

// Module: jelly_data_combine_pack_n
//
// PURPOSE
//  N-channel stream combiner: NUM independent valid/ready input streams of equal width are
//  joined into one wide output word, one element taken from each enabled channel.
//  Each channel has its own small FIFO, so producers running at different rates do not stall
//  one another until that channel's FIFO is full.
//  A run-time lane-enable mask lets lanes be dropped or flushed without a reset.
//  Sits between multi-source producers (e.g. sensor planes, DMA readers) and packed consumers.
//
// PARAMETERS
//  NUM            3   number of input channels (>=1)
//  DATA_WIDTH     8   width of one channel element
//  FIFO_PTR_WIDTH 2   per-channel FIFO depth = 2**FIFO_PTR_WIDTH (>=1)
//  COUNT_WIDTH    16  width of the combined-word counter
//
// PORTS
//  aclk       in   1                clock
//  aresetn    in   1                asynchronous reset, active low
//  cke        in   1                clock enable; low freezes all state
//  enable     in   NUM              lane enable mask, bit i = channel i
//  s_data     in   NUM*DATA_WIDTH   channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
//  s_valid    in   NUM              per-channel valid
//  s_ready    out  NUM              per-channel ready
//  m_data     out  NUM*DATA_WIDTH   combined word, same lane layout as s_data
//  m_enable   out  NUM              mask snapshot that applies to m_data
//  m_valid    out  1                output valid
//  m_ready    in   1                output ready
//  fifo_level out  NUM*(FIFO_PTR_WIDTH+1)  per-channel FIFO occupancy
//  m_count    out  COUNT_WIDTH      number of words accepted at the output
//
// BEHAVIOUR
//  - One clock (aclk). aresetn is asynchronous and active low. Reset clears all FIFOs,
//    m_valid=0, m_data=0, m_enable=0, m_count=0, fifo_level=0.
//  - Every state update requires cke=1. A handshake counts only when cke=1.
//  - Input transfer on channel i: s_valid[i] & s_ready[i] & cke.
//  - Enabled lane: s_ready[i] = !full[i]. Ready is decoded from state only, never from s_valid.
//    A full FIFO accepts no push, even in a cycle where it pops.
//  - Disabled lane: s_ready[i]=1 and input data is discarded.
//    On each cke cycle with enable[i]=0, FIFO i is flushed (level goes to 0).
//  - Combine fires when all of the following hold:
//      cke; enable != 0; every enabled FIFO is non-empty; (!m_valid | m_ready).
//    On fire: pop one entry from each enabled FIFO; register m_data (disabled lanes = 0);
//    set m_enable = enable; set m_valid = 1.
//  - Otherwise, if m_valid & m_ready & cke, then m_valid goes to 0.
//  - Latency: a push at edge t makes the FIFO non-empty after t. The earliest fire is at
//    edge t+1, so m_valid is high after t+1 (2 cycles input to output).
//    Throughput is 1 word/cycle when all lanes are streaming.
//  - Output is fully registered. m_data and m_enable hold stable while m_valid & !m_ready.
//  - enable = 0: no fire; all s_ready=1; all FIFOs flushed. A pending m_valid word is kept.
//  - Changing the mask takes effect at the next fire. Data already in the output register
//    keeps its m_enable snapshot.
//  - FIFO order is strict per channel. Push and pop in the same cycle on a non-full FIFO
//    leave its level unchanged.
//  - m_count increments on m_valid & m_ready & cke and wraps modulo 2**COUNT_WIDTH.
//  - Reset asserted mid-transfer discards all buffered data. There is no partial output.
//
// TESTING
//  1 NUM=3, all enabled, lanes always valid, m_ready=1: ch0=1,2,3 ch1=10,11,12 ch2=20,21,22
//    -> words {20,10,1},{21,11,2},{22,12,3} on consecutive cycles; first m_valid 2 cycles
//    after the first push.
//  2 Hold s_valid[1]=0 while ch0 and ch2 push 5 items, depth 4 -> s_ready[0] and s_ready[2]
//    drop after 4 pushes; fifo_level = 4,0,4; no m_valid until ch1 pushes, then the words
//    stay in order.
//  3 enable=3'b101 with ch1 idle -> words output with lane1 = 0 and m_enable=101;
//    s_ready[1]=1; fifo_level[1]=0.
//  4 m_ready=0 for 10 cycles with all lanes streaming -> m_data stable; each FIFO fills
//    to 4; no loss or duplication after release.
//  5 Random cke, valid and ready for 10k cycles -> output sequence matches a scoreboard;
//    m_count equals the number of words accepted mod 2**16.
//  6 Drop aresetn asynchronously mid-stream -> all outputs reach reset values before
//    the next aclk edge; stream restarts cleanly.

Source files
------------

// File: rtl/jelly_data_combine_pack_n.sv
// Joins NUM per-channel valid/ready streams into one registered wide word; 2 cycles input to output.
// Backpressure: each lane buffers in its own FIFO and drops s_ready only when that FIFO is full.

module jelly_data_combine_pack_n_fifo #(
  parameter int WIDTH     = 8,
  parameter int PTR_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cke,
  input  logic                 flush,
  input  logic                 push,
  input  logic [WIDTH-1:0]     din,
  input  logic                 pop,
  output logic [WIDTH-1:0]     dout,
  output logic                 full,
  output logic                 empty,
  output logic [PTR_WIDTH:0]   level
);
  localparam int DEPTH = 1 << PTR_WIDTH;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (level == {1'b1, {PTR_WIDTH{1'b0}}});
  assign empty   = (level == '0);
  // A full FIFO refuses a push even when it pops in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (cke) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        level <= level + (PTR_WIDTH+1)'(do_push) - (PTR_WIDTH+1)'(do_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cke && do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

module jelly_data_combine_pack_n #(
  parameter int NUM            = 3,
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_PTR_WIDTH = 2,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic                              cke,
  input  logic [NUM-1:0]                    enable,
  input  logic [NUM*DATA_WIDTH-1:0]         s_data,
  input  logic [NUM-1:0]                    s_valid,
  output logic [NUM-1:0]                    s_ready,
  output logic [NUM*DATA_WIDTH-1:0]         m_data,
  output logic [NUM-1:0]                    m_enable,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [NUM*(FIFO_PTR_WIDTH+1)-1:0] fifo_level,
  output logic [COUNT_WIDTH-1:0]            m_count
);
  logic [NUM-1:0]            full;
  logic [NUM-1:0]            empty;
  logic [NUM*DATA_WIDTH-1:0] head_flat;
  logic [NUM*DATA_WIDTH-1:0] comb_data;
  logic                      fire;

  // Disabled lanes always accept and are flushed, so they never hold up the combine.
  assign s_ready = ~enable | ~full;
  assign fire    = cke & (|enable) & (&(~enable | ~empty)) & (~m_valid | m_ready);

  for (genvar i = 0; i < NUM; i++) begin : g_lane
    jelly_data_combine_pack_n_fifo #(
      .WIDTH     (DATA_WIDTH),
      .PTR_WIDTH (FIFO_PTR_WIDTH)
    ) u_fifo (
      .clk   (aclk),
      .rst_n (aresetn),
      .cke   (cke),
      .flush (~enable[i]),
      .push  (enable[i] & s_valid[i]),
      .din   (s_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .pop   (fire & enable[i]),
      .dout  (head_flat[i*DATA_WIDTH +: DATA_WIDTH]),
      .full  (full[i]),
      .empty (empty[i]),
      .level (fifo_level[i*(FIFO_PTR_WIDTH+1) +: FIFO_PTR_WIDTH+1])
    );
  end

  always_comb begin
    comb_data = '0;
    for (int i = 0; i < NUM; i++) begin
      if (enable[i]) comb_data[i*DATA_WIDTH +: DATA_WIDTH] = head_flat[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_data   <= '0;
      m_enable <= '0;
      m_valid  <= 1'b0;
    end else if (fire) begin
      m_data   <= comb_data;
      m_enable <= enable;
      m_valid  <= 1'b1;
    end else if (cke && m_valid && m_ready) begin
      m_valid  <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_count <= '0;
    end else if (cke && m_valid && m_ready) begin
      m_count <= m_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_jelly_data_combine_pack_n.sv
// Bench for jelly_data_combine_pack_n: directed scenarios plus random traffic against a
// queue-based reference model of the per-lane buffering and output register.
module tb_jelly_data_combine_pack_n;
  localparam int NUM   = 3;
  localparam int DW    = 8;
  localparam int PW    = 2;
  localparam int CW    = 16;
  localparam int DEPTH = 1 << PW;

  logic                   aclk = 1'b0;
  logic                   aresetn = 1'b0;
  logic                   cke = 1'b0;
  logic [NUM-1:0]         enable = '0;
  logic [NUM*DW-1:0]      s_data = '0;
  logic [NUM-1:0]         s_valid = '0;
  logic [NUM-1:0]         s_ready;
  logic [NUM*DW-1:0]      m_data;
  logic [NUM-1:0]         m_enable;
  logic                   m_valid;
  logic                   m_ready = 1'b0;
  logic [NUM*(PW+1)-1:0]  fifo_level;
  logic [CW-1:0]          m_count;

  jelly_data_combine_pack_n #(
    .NUM(NUM), .DATA_WIDTH(DW), .FIFO_PTR_WIDTH(PW), .COUNT_WIDTH(CW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .cke(cke), .enable(enable),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_enable(m_enable), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_level(fifo_level), .m_count(m_count)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  // Reference model state: one queue per lane plus the output register contents.
  logic [DW-1:0]     mq [NUM][$];
  logic              mv;
  logic [NUM*DW-1:0] md;
  logic [NUM-1:0]    me;
  logic [CW-1:0]     mcnt;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM; i++) mq[i].delete();
    mv = 1'b0; md = '0; me = '0; mcnt = '0;
  endtask

  // Applies the inputs that were present at the clock edge to the model.
  task automatic model_update();
    logic [NUM-1:0]    rdy;
    logic              all_have;
    logic              fire;
    logic              acc;
    logic [NUM*DW-1:0] word;
    if (!cke) return;
    all_have = 1'b1;
    for (int i = 0; i < NUM; i++) begin
      rdy[i] = !enable[i] || (mq[i].size() < DEPTH);
      if (enable[i] && mq[i].size() == 0) all_have = 1'b0;
    end
    acc  = mv && m_ready;
    fire = (enable != '0) && all_have && (!mv || m_ready);
    word = '0;
    for (int i = 0; i < NUM; i++) begin
      if (!enable[i]) begin
        mq[i].delete();
      end else begin
        if (fire) word[i*DW +: DW] = mq[i].pop_front();
        if (s_valid[i] && rdy[i]) mq[i].push_back(s_data[i*DW +: DW]);
      end
    end
    if (acc) mcnt = mcnt + 1'b1;
    if (fire) begin
      mv = 1'b1; md = word; me = enable;
    end else if (acc) begin
      mv = 1'b0;
    end
  endtask

  task automatic check_outputs();
    logic [NUM*(PW+1)-1:0] lvl;
    logic [NUM-1:0]        rdy;
    for (int i = 0; i < NUM; i++) begin
      lvl[i*(PW+1) +: PW+1] = (PW+1)'(mq[i].size());
      rdy[i] = !enable[i] || (mq[i].size() < DEPTH);
    end
    check("m_valid", 64'(m_valid), 64'(mv));
    check("m_data", 64'(m_data), 64'(md));
    check("m_enable", 64'(m_enable), 64'(me));
    check("m_count", 64'(m_count), 64'(mcnt));
    check("fifo_level", 64'(fifo_level), 64'(lvl));
    check("s_ready", 64'(s_ready), 64'(rdy));
  endtask

  task automatic step(input logic c, input logic [NUM-1:0] en, input logic [NUM-1:0] sv,
                      input logic [NUM*DW-1:0] sd, input logic mr);
    cke = c; enable = en; s_valid = sv; s_data = sd; m_ready = mr;
    @(posedge aclk);
    model_update();
    @(negedge aclk);
    check_outputs();
  endtask

  // Asserts reset between edges and checks outputs clear before the next edge.
  task automatic async_reset();
    #2 aresetn = 1'b0;
    #1;
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_m_enable", 64'(m_enable), 64'd0);
    check("rst_m_count", 64'(m_count), 64'd0);
    check("rst_fifo_level", 64'(fifo_level), 64'd0);
    model_clear();
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  function automatic logic [NUM*DW-1:0] rnd_data();
    return {NUM*DW{1'b0}} | (NUM*DW)'($urandom());
  endfunction

  initial begin
    logic [NUM*DW-1:0] d;
    model_clear();
    enable = 3'b111;
    @(negedge aclk);
    async_reset();
    check_outputs();

    // Lanes streaming with free output: first word two cycles after the first push.
    step(1, 3'b111, 3'b111, {8'd20, 8'd10, 8'd1}, 1);
    check("first_not_yet", 64'(m_valid), 64'd0);
    step(1, 3'b111, 3'b111, {8'd21, 8'd11, 8'd2}, 1);
    check("first_word", 64'(m_data), 64'h140A01);
    step(1, 3'b111, 3'b111, {8'd22, 8'd12, 8'd3}, 1);
    check("second_word", 64'(m_data), 64'h150B02);
    for (int k = 0; k < 4; k++) step(1, 3'b111, 3'b000, rnd_data(), 1);

    // Lane 1 starved: lanes 0 and 2 fill to depth and stall.
    for (int k = 0; k < 5; k++) step(1, 3'b111, 3'b101, rnd_data(), 1);
    check("starve_level", 64'(fifo_level), 64'({3'd4, 3'd0, 3'd4}));
    check("starve_ready", 64'(s_ready), 64'(3'b010));
    for (int k = 0; k < 4; k++) step(1, 3'b111, 3'b010, rnd_data(), 1);
    for (int k = 0; k < 4; k++) step(1, 3'b111, 3'b000, rnd_data(), 1);

    // Lane 1 disabled while idle.
    for (int k = 0; k < 5; k++) step(1, 3'b101, 3'b101, rnd_data(), 1);
    check("mask_enable", 64'(m_enable), 64'(3'b101));
    check("mask_lane1_zero", 64'(m_data[DW +: DW]), 64'd0);
    check("mask_ready1", 64'(s_ready[1]), 64'd1);

    // Output stalled for 10 cycles, then released.
    for (int k = 0; k < 10; k++) step(1, 3'b111, 3'b111, rnd_data(), 0);
    check("stall_level", 64'(fifo_level), 64'({3'd4, 3'd4, 3'd4}));
    for (int k = 0; k < 8; k++) step(1, 3'b111, 3'b000, rnd_data(), 1);

    // Random traffic with a mid-stream asynchronous reset.
    for (int k = 0; k < 10000; k++) begin
      logic [NUM-1:0] en;
      en = ($urandom_range(0, 19) == 0) ? NUM'($urandom()) : 3'b111;
      d = rnd_data();
      step($urandom_range(0, 9) < 8, en, NUM'($urandom()), d, $urandom_range(0, 3) != 0);
      if (k == 5000) begin
        async_reset();
        check_outputs();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
